// File: rtl/lfsr16_pkg.sv
// Shared constants and state encoding for the 16-bit Galois PRBS link-test path.
// Both the receive-side checker and the transmitter generator import this package.
package lfsr16_pkg;

    localparam int unsigned LFSR_W = 16;

    // Tap positions of x^16 + x^14 + x^13 + x^11 + 1, as seen in the history window
    localparam int unsigned TAP_A = 15;
    localparam int unsigned TAP_B = 13;
    localparam int unsigned TAP_C = 12;
    localparam int unsigned TAP_D = 10;

    // Galois feedback mask used by the generator: feedback into bit 15, XOR into 13, 12, 10
    localparam logic [LFSR_W-1:0] GALOIS_MASK = 16'hB400;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr16_predict.sv
// Next-bit predictor from a 16-bit history window (H[0] newest, H[15] oldest).
// Purely combinational so it can be replicated by a parallel checker.
module lfsr16_predict
    import lfsr16_pkg::*;
(
    input  logic [LFSR_W-1:0] hist,
    output logic              pred_c
);

    // s[n+16] = s[n] ^ s[n+2] ^ s[n+3] ^ s[n+5]
    assign pred_c = hist[TAP_A] ^ hist[TAP_B] ^ hist[TAP_C] ^ hist[TAP_D];

endmodule

// File: rtl/lfsr16_checker.sv
// Self-synchronising PRBS16 checker: fills a history window, searches for a run of
// correct predictions, then free-runs the predictor and counts bit errors.
module lfsr16_checker
    import lfsr16_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = 32,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned FILL_W  = $clog2(LFSR_W + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_THRESH + 1);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic                locked_d;
    logic                err_pulse_d;
    logic [CNT_W-1:0]    bit_count_d, err_count_d;
    logic                pred_c;

    lfsr16_predict u_predict (
        .hist   (hist_q),
        .pred_c (pred_c)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state, history and counter update
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        bit_count_d = bit_count;
        err_count_d = err_count;

        if (din_valid) begin
            unique case (state_q)
                FILL: begin
                    hist_d     = {hist_q[LFSR_W-2:0], din};
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    if (fill_cnt_q == FILL_W'(LFSR_W - 1)) begin
                        state_d     = SEARCH;
                        match_cnt_d = '0;
                    end
                end
                SEARCH: begin
                    hist_d = {hist_q[LFSR_W-2:0], din};
                    // an all-zero window predicts zeros forever; never count it as a match
                    if ((din == pred_c) && (hist_q != '0)) begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                        if (match_cnt_d == MATCH_W'(LOCK_THRESH)) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // shift the prediction, not din, so errors do not corrupt the window
                    hist_d      = {hist_q[LFSR_W-2:0], pred_c};
                    bit_count_d = sat_inc(bit_count);
                    if (din != pred_c) begin
                        err_pulse_d = 1'b1;
                        err_count_d = sat_inc(err_count);
                        miss_cnt_d  = miss_cnt_q + MISS_W'(1);
                        if (miss_cnt_d == MISS_W'(LOSS_THRESH)) begin
                            state_d    = FILL;
                            fill_cnt_d = '0;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                end
            endcase
        end

        if (clr_counts) begin
            bit_count_d = '0;
            err_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= FILL;
            hist_q      <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            bit_count   <= '0;
            err_count   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked      <= locked_d;
            err_pulse   <= err_pulse_d;
            bit_count   <= bit_count_d;
            err_count   <= err_count_d;
        end
    end

endmodule

// File: doc/lfsr16_checker.md
# lfsr16_checker

Serial PRBS checker for the 16-bit Galois LFSR stream (feedback into bit 15; XOR taps into bits 13, 12, 10; output bit = Q[0] each clock). Sits at the receive end of the link-test path. It self-synchronises from received bits, declares lock, then free-runs a local predictor and counts bit errors. It does not need the transmitter seed.

## Interface
- LOCK_THRESH, default 32: consecutive correct predictions needed to enter LOCKED.
- LOSS_THRESH, default 8: consecutive mispredictions in LOCKED that force resync.
- CNT_W, default 32: width of the bit and error counters.

- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-high reset
- din  input  1  received serial bit
- din_valid  input  1  din is sampled only when high
- clr_counts  input  1  synchronous clear of bit_count and err_count
- locked  output  1  high in LOCKED state
- err_pulse  output  1  one-cycle pulse per counted bit error
- bit_count  output  CNT_W  bits checked while locked, saturating
- err_count  output  CNT_W  errors counted while locked, saturating

## Operation
- History register H[15:0]. H[0] holds the newest bit and H[15] the oldest. A shift moves H[i] to H[i+1] and places the new bit in H[0].
- Prediction: pred = H[15]^H[13]^H[12]^H[10]. This follows from the recurrence s[n+16] = s[n]^s[n+2]^s[n+3]^s[n+5].
- States (2-bit enum):
  - FILL: on each valid bit, shift din into H and increment fill_cnt. After 16 bits, go to SEARCH with match_cnt=0.
  - SEARCH: on each valid bit, shift din into H.
    - If din==pred and H!=0, increment match_cnt.
    - Otherwise set match_cnt=0. This rejects the all-zero lock-up sequence.
    - When match_cnt reaches LOCK_THRESH, go to LOCKED with miss_cnt=0.
  - LOCKED: on each valid bit, shift pred (not din) into H, so the predictor free-runs. Increment bit_count.
    - If din!=pred: pulse err_pulse, increment err_count and miss_cnt.
    - Otherwise: clear miss_cnt.
    - When miss_cnt reaches LOSS_THRESH, go to FILL with fill_cnt=0. This mismatch is still counted.
- Counters saturate at all-ones and never wrap.
- clr_counts zeroes both counters. It has priority over an increment in the same cycle. State and H are unaffected.
- With din_valid low, nothing changes and err_pulse is 0.

## Timing
- Reset values:
  - state=FILL, H=0, fill_cnt=0, match_cnt=0, miss_cnt=0.
  - locked=0, err_pulse=0, bit_count=0, err_count=0.
- All outputs are registered.
  - A bit sampled at edge k updates err_pulse and the counters after edge k, so they are visible in cycle k+1.
  - locked rises in the cycle after the LOCK_THRESH-th match is sampled.
- Minimum lock time from reset with a clean stream: 16 + LOCK_THRESH valid bits.
- Reset asserted mid-operation returns immediately to the reset state, whatever the current state.
- din_valid may be high every cycle, and gaps of any length are allowed.

## Structure
- Package lfsr16_pkg holds:
  - the state enum typedef (FILL, SEARCH, LOCKED);
  - the tap-position constants (15, 13, 12, 10) and the LFSR width constant 16.
- The transmitter side should also use lfsr16_pkg.
- One sub-module, lfsr16_predict: purely combinational, H to pred. It is shared with a future parallel checker.

## Test plan
- Clean lock: drive the generator stream from seed 16'hACE1 (first bit 1) continuously.
  - locked rises after exactly 16+32 bits.
  - err_count stays 0, and bit_count equals the number of bits after lock.
- Single error: once locked, invert one bit.
  - Exactly one err_pulse; err_count=1; locked stays 1.
  - The next bit matches, with no error multiplication.
- Loss of lock: once locked, feed 8 consecutive inverted bits.
  - err_count=8; locked falls in the cycle after the 8th error.
  - The checker relocks after a further 48 clean bits.
- All-zero input: feed 200 zero bits.
  - locked never rises; match_cnt is always 0; counters stay 0.
- Gaps and clear: insert random din_valid=0 gaps in the clean stream.
  - Lock occurs after 48 valid bits.
  - Pulse clr_counts in the same cycle as an error: err_count reads 0 afterwards.
- Reset and saturation:
  - Assert RESET mid-LOCKED: all outputs are 0 immediately.
  - With CNT_W=4, inject 20 errors spaced apart: err_count holds at 15.
